// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the M-stage data-memory sequencer.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wait counter only has to reach TIMEOUT-1, so one bit suffices for TIMEOUT of 1 or 2.
  function automatic int cnt_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables and replicated store data on the request
// side, lane extraction and sign/zero extension on the response side.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata_rep,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_rdata_ext
);

  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;

  always_comb begin
    req_be        = 4'b1111;
    req_wdata_rep = req_wdata;
    case (req_funct3)
      F3_B, F3_BU: begin
        req_be        = 4'b0001 << req_addr_lo;
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        req_be        = 4'b0011 << req_addr_lo;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Halfwords are always aligned here, so only addr[1] selects the half.
  always_comb begin
    rsp_byte      = rsp_rdata[{rsp_addr_lo, 3'b000} +: 8];
    rsp_half      = rsp_rdata[{rsp_addr_lo[1], 4'b0000} +: 16];
    rsp_rdata_ext = rsp_rdata;
    case (rsp_funct3)
      F3_B:    rsp_rdata_ext = {{24{rsp_byte[7]}}, rsp_byte};
      F3_BU:   rsp_rdata_ext = {24'd0, rsp_byte};
      F3_H:    rsp_rdata_ext = {{16{rsp_half[15]}}, rsp_half};
      F3_HU:   rsp_rdata_ext = {16'd0, rsp_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage data-memory sequencer: issues one valid/ready request per load/store,
// stalls the pipeline until the response (or timeout), and returns extended load data.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallPipe,
  output logic [31:0] ReadDataM,
  output logic        AccessErrM,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [3:0]  dmem_req_be,
  output logic [31:0] dmem_req_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_valid_q, req_valid_d;
  logic          req_we_q, req_we_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [3:0]    req_be_q, req_be_d;
  logic [31:0]   req_wdata_q, req_wdata_d;
  logic [2:0]    lane_f3_q, lane_f3_d;
  logic [1:0]    lane_lo_q, lane_lo_d;
  logic [31:0]   read_data_q, read_data_d;

  logic          f3_ok, aligned, op_valid, op_legal;
  logic [3:0]    new_be;
  logic [31:0]   new_wdata, rsp_ext;

  mem_lane_align u_lane (
    .req_funct3    (Funct3M),
    .req_addr_lo   (ALUResultM[1:0]),
    .req_wdata     (WriteDataM),
    .req_be        (new_be),
    .req_wdata_rep (new_wdata),
    .rsp_funct3    (lane_f3_q),
    .rsp_addr_lo   (lane_lo_q),
    .rsp_rdata     (dmem_rsp_rdata),
    .rsp_rdata_ext (rsp_ext)
  );

  always_comb begin
    f3_ok   = 1'b0;
    aligned = 1'b0;
    case (Funct3M)
      F3_B, F3_BU: begin
        f3_ok   = 1'b1;
        aligned = 1'b1;
      end
      F3_H, F3_HU: begin
        f3_ok   = 1'b1;
        aligned = ~ALUResultM[0];
      end
      F3_W: begin
        f3_ok   = 1'b1;
        aligned = (ALUResultM[1:0] == 2'b00);
      end
      default: ;
    endcase
    op_valid = MemReadM | MemWriteM;
    op_legal = f3_ok & aligned & ~(MemReadM & MemWriteM) & ~(MemWriteM & Funct3M[2]);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_be_d    = req_be_q;
    req_wdata_d = req_wdata_q;
    lane_f3_d   = lane_f3_q;
    lane_lo_d   = lane_lo_q;
    read_data_d = read_data_q;
    StallPipe   = 1'b0;
    AccessErrM  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid && op_legal) begin
          StallPipe   = 1'b1;
          req_valid_d = 1'b1;
          req_we_d    = MemWriteM;
          req_addr_d  = {ALUResultM[31:2], 2'b00};
          req_be_d    = new_be;
          req_wdata_d = new_wdata;
          lane_f3_d   = Funct3M;
          lane_lo_d   = ALUResultM[1:0];
          state_d     = ST_REQ;
        end else if (op_valid) begin
          AccessErrM  = 1'b1;
          read_data_d = 32'd0;
        end
      end
      ST_REQ: begin
        StallPipe = 1'b1;
        if (dmem_req_ready) begin
          req_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        StallPipe = 1'b1;
        // A response arriving in the timeout cycle still completes normally.
        if (dmem_rsp_valid) begin
          if (!req_we_q) read_data_d = rsp_ext;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          AccessErrM  = 1'b1;
          read_data_d = 32'd0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= 32'd0;
      req_be_q    <= 4'd0;
      req_wdata_q <= 32'd0;
      lane_f3_q   <= 3'd0;
      lane_lo_q   <= 2'd0;
      read_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_be_q    <= req_be_d;
      req_wdata_q <= req_wdata_d;
      lane_f3_q   <= lane_f3_d;
      lane_lo_q   <= lane_lo_d;
      read_data_q <= read_data_d;
    end
  end

  assign ReadDataM      = read_data_q;
  assign dmem_req_valid = req_valid_q;
  assign dmem_req_we    = req_we_q;
  assign dmem_req_addr  = req_addr_q;
  assign dmem_req_be    = req_be_q;
  assign dmem_req_wdata = req_wdata_q;

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencer for the data-memory access of the instruction held in the EX/MEM pipeline register. When that instruction is a load or store, the block issues one request to a variable-latency data memory over a valid/ready handshake. It holds `StallPipe` high to freeze the upstream pipeline registers until the response arrives. It formats byte/half/word lanes and delivers a sign- or zero-extended `ReadDataM` in the cycle the pipeline is released.

## Interface
- `TIMEOUT`, default 64: maximum WAIT cycles before the access is abandoned. Must be ≥1.
- `clk`  in  1  rising-edge clock.
- `nrst`  in  1  asynchronous, active-low reset.
- `MemReadM`  in  1  M-stage instruction is a load.
- `MemWriteM`  in  1  M-stage instruction is a store. Read and write both high is treated as an access error.
- `Funct3M`  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU. All other codes are illegal. BU/HU are illegal for stores.
- `ALUResultM`  in  32  byte address.
- `WriteDataM`  in  32  store data, right-aligned.
- `StallPipe`  out  1  freeze the IF/ID, ID/EX and EX/MEM registers. Combinational.
- `ReadDataM`  out  32  extended load data. Valid in the DONE cycle, held until the next access completes.
- `AccessErrM`  out  1  one-cycle pulse: misaligned, illegal, or timed-out access.
- `dmem_req_valid`  out  1  request valid.
- `dmem_req_ready`  in  1  memory accepts the request.
- `dmem_req_we`  out  1  1 = write.
- `dmem_req_addr`  out  32  word address `{addr[31:2],2'b00}`.
- `dmem_req_be`  out  4  byte enables.
- `dmem_req_wdata`  out  32  lane-replicated store data.
- `dmem_rsp_valid`  in  1  response strobe. Stores also receive one response.
- `dmem_rsp_rdata`  in  32  response word.

## Operation
- **FSM states:** IDLE, REQ, WAIT, DONE.
- **IDLE:**
  - With a legal, aligned memory op: latch addr, we, be, wdata and the lane/sign info, then go to REQ. StallPipe is 1 in this cycle.
  - With an illegal or misaligned op: pulse AccessErrM, issue no request, StallPipe 0, ReadDataM ← 0, stay in IDLE.
  - With no op: stay in IDLE, StallPipe 0.
- **REQ:**
  - `dmem_req_valid` = 1, and all request fields are held stable from the latched values.
  - If `dmem_req_ready`, go to WAIT and clear the wait counter.
  - A response is never accepted in REQ.
- **WAIT:**
  - On `dmem_rsp_valid`: capture the aligned and extended rdata (loads only) and go to DONE.
  - Otherwise increment the counter. When counter == TIMEOUT−1, pulse AccessErrM, set ReadDataM ← 0, and go to DONE.
  - If a response arrives in the same cycle the timeout would fire, the response wins.
- **DONE:** StallPipe 0, so the pipeline advances on this edge. Go unconditionally to IDLE.
  - A back-to-back memory op is seen in the following IDLE cycle.
  - DONE exists so that a frozen EX/MEM register is never re-issued.
- **StallPipe** = (IDLE ∧ legal op) ∨ REQ ∨ WAIT.
- **Alignment:** H requires addr[0] = 0. W requires addr[1:0] = 0.
- **Byte enables:** B → `4'b0001<<addr[1:0]`; H → `4'b0011<<addr[1:0]`; W → `4'b1111`.
- **Store data:** B replicates byte [7:0] ×4; H replicates half [15:0] ×2; W passes through.
- **Load data:** shift rdata right by addr[1:0]×8, then take [7:0] or [15:0]. Sign-extend for B/H, zero-extend for BU/HU. W passes through.
- **Store-only completion:** ReadDataM is left unchanged.
- **Stray responses:** `dmem_rsp_valid` outside WAIT is ignored.

## Timing
- **Reset values:** state IDLE, counter 0, StallPipe 0, ReadDataM 0, AccessErrM 0, `dmem_req_valid` 0, `dmem_req_we` 0, addr/wdata 0, be 0.
- **Reset mid-access:** nrst low in any state forces IDLE and all reset values immediately (asynchronous). An in-flight response is dropped.
- **Minimum latency:** op appears at cycle 0 (IDLE); REQ with ready at cycle 1; WAIT with rsp at cycle 2; DONE at cycle 3. That is 3 stall cycles, and the instruction leaves M on the edge ending cycle 3.
- **General stall count:** stall cycles = 1 + (REQ cycles) + (WAIT cycles).
- **Timeout path:** stall = 1 + REQ cycles + TIMEOUT.
- **ReadDataM register:** updates on the edge entering DONE.
- **Output registration:** all `dmem_req_*` outputs are registered. StallPipe and AccessErrM (IDLE case) are combinational from state and inputs.

## Structure
- **Package `mem_ctrl_pkg`:** state enum `mem_state_t`, Funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`), and `TIMEOUT` width helper.
- **Sub-module `mem_lane_align`:** combinational. Computes be, replicated wdata and extended rdata from Funct3, addr[1:0] and the data words. Instantiated once for the request side and once for the response side, or as a single instance with both paths.
- **Top level (`mem_stage_ctrl`):** FSM, counter and latches.

## Test plan
- LW at 0x100, ready immediately, rsp 2 cycles after accept with 0xDEADBEEF → StallPipe high 4 cycles, ReadDataM = 0xDEADBEEF in DONE, req_addr 0x100, be 1111.
- LB at 0x103 with rsp 0x80FF_FFFF → ReadDataM 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at 0x102 with WriteDataM 0x1234ABCD → be 1100, wdata 0xABCDABCD, we 1, ReadDataM unchanged.
- LW at 0x101 → AccessErrM pulse, no `dmem_req_valid`, StallPipe never asserts. Funct3 011 behaves the same way.
- TIMEOUT=4, ready held low 3 cycles, then no response → AccessErrM in the 4th WAIT cycle, ReadDataM 0, then IDLE.
- nrst asserted during WAIT, then a back-to-back LW/SW after release → all outputs at reset values; second op starts in the IDLE cycle after DONE with correct request fields.
